// File: rtl/bl_wl_config_loader.sv
// bl_wl_config_loader
// Drives a memory tile's chained bl_in/wl_in configuration ports. Bitstream
// chunks arrive over a valid/ready handshake and are shifted into one bit-line
// word per row. The word is then held stable while a single word line pulses,
// with one guard cycle before and after the pulse. Rows 0..WL_WIDTH-1 are
// walked once per start, then done pulses for one cycle.
//
// Ports
//   prog_clk   programming clock, all state on the rising edge
//   pReset     asynchronous active-high reset
//   start      begin a full load (only looked at while idle)
//   abort      synchronous abort, honoured in any non-idle state
//   din        bitstream chunk, DIN_WIDTH bits
//   din_valid  din qualifier
//   din_ready  loader accepts din this cycle (decoded from state)
//   bl         bit-line word to tile bl_in
//   wl         one-hot word line to tile wl_in
//   busy       high whenever not idle
//   done       one-cycle pulse on load completion
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; outputs quiet, bl keeps its last value
// S_SHIFT | accepting chunks for the current row; wl forced low
// S_SETUP | one guard cycle, bl stable before the word line rises
// S_PULSE | word line of the current row held high for WL_PULSE cycles
// S_HOLD  | one guard cycle after the word line falls; next row or finish
// S_DONE  | done pulse, back to idle on the next edge

module bl_wl_config_loader #(
    parameter int BL_WIDTH  = 40,
    parameter int WL_WIDTH  = 4,
    parameter int DIN_WIDTH = 8,
    parameter int WL_PULSE  = 2
) (
    input  logic                 prog_clk,
    input  logic                 pReset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [DIN_WIDTH-1:0] din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic [BL_WIDTH-1:0]  bl,
    output logic [WL_WIDTH-1:0]  wl,
    output logic                 busy,
    output logic                 done
);

    localparam int NCHUNK = BL_WIDTH / DIN_WIDTH;
    localparam int CW     = (NCHUNK   > 1) ? $clog2(NCHUNK)   : 1;
    localparam int RW     = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1;
    localparam int PW     = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

    localparam logic [CW-1:0] CHUNK_LAST = CW'(NCHUNK - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(WL_WIDTH - 1);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(WL_PULSE - 1);

    generate
        if ((BL_WIDTH % DIN_WIDTH) != 0 || BL_WIDTH < DIN_WIDTH) begin : g_bad_din
            $error("BL_WIDTH must be an integer multiple of DIN_WIDTH");
        end
        if (WL_PULSE < 1) begin : g_bad_pulse
            $error("WL_PULSE must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] chunk_cnt;
    logic [RW-1:0] row;
    logic [PW-1:0] pulse_cnt;
    logic [BL_WIDTH-1:0] bl_shifted;

    // With a single chunk per row the chunk simply replaces the word.
    generate
        if (NCHUNK == 1) begin : g_one_chunk
            assign bl_shifted = din;
        end else begin : g_multi_chunk
            assign bl_shifted = {bl[BL_WIDTH-DIN_WIDTH-1:0], din};
        end
    endgenerate

    assign din_ready = (state == S_SHIFT);

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state     <= S_IDLE;
            chunk_cnt <= '0;
            row       <= '0;
            pulse_cnt <= '0;
            bl        <= '0;
            wl        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            // Abort beats every transition, including completion from the last HOLD.
            if (abort && state != S_IDLE) begin
                state <= S_IDLE;
                wl    <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state     <= S_SHIFT;
                            bl        <= '0;
                            row       <= '0;
                            chunk_cnt <= '0;
                            busy      <= 1'b1;
                        end
                    end
                    S_SHIFT: begin
                        if (din_valid) begin
                            bl <= bl_shifted;
                            if (chunk_cnt == CHUNK_LAST) begin
                                state <= S_SETUP;
                            end else begin
                                chunk_cnt <= chunk_cnt + CW'(1);
                            end
                        end
                    end
                    S_SETUP: begin
                        state     <= S_PULSE;
                        wl        <= WL_WIDTH'(1) << row;
                        pulse_cnt <= PULSE_LOAD;
                    end
                    S_PULSE: begin
                        if (pulse_cnt == '0) begin
                            state <= S_HOLD;
                            wl    <= '0;
                        end else begin
                            pulse_cnt <= pulse_cnt - PW'(1);
                        end
                    end
                    S_HOLD: begin
                        if (row == ROW_LAST) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            // bl is left as is; the next row's chunks overwrite all of it.
                            state     <= S_SHIFT;
                            row       <= row + RW'(1);
                            chunk_cnt <= '0;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        wl    <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bl_wl_config_loader.sv
module tb_bl_wl_config_loader;

    localparam int BLW   = 40;
    localparam int WLW   = 4;
    localparam int DW    = 8;
    localparam int PULSE = 2;
    localparam int NCH   = BLW / DW;

    logic           prog_clk = 1'b0;
    logic           pReset   = 1'b1;
    logic           start    = 1'b0;
    logic           abort    = 1'b0;
    logic [DW-1:0]  din      = '0;
    logic           din_valid = 1'b0;
    logic           din_ready;
    logic [BLW-1:0] bl;
    logic [WLW-1:0] wl;
    logic           busy;
    logic           done;

    // Second instance for the one-chunk / one-row / one-cycle-pulse corner.
    logic           s_start = 1'b0;
    logic           s_abort = 1'b0;
    logic [39:0]    s_din   = '0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [39:0]    s_bl;
    logic [0:0]     s_wl;
    logic           s_busy;
    logic           s_done;

    int tests = 0;
    int fails = 0;

    bl_wl_config_loader #(.BL_WIDTH(BLW), .WL_WIDTH(WLW), .DIN_WIDTH(DW), .WL_PULSE(PULSE)) dut (
        .prog_clk(prog_clk), .pReset(pReset), .start(start), .abort(abort),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .bl(bl), .wl(wl), .busy(busy), .done(done)
    );

    bl_wl_config_loader #(.BL_WIDTH(40), .WL_WIDTH(1), .DIN_WIDTH(40), .WL_PULSE(1)) dut_s (
        .prog_clk(prog_clk), .pReset(pReset), .start(s_start), .abort(s_abort),
        .din(s_din), .din_valid(s_valid), .din_ready(s_ready),
        .bl(s_bl), .wl(s_wl), .busy(s_busy), .done(s_done)
    );

    always #5 prog_clk = ~prog_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: progress through a load is tracked as "which row,
    // how many chunks of it have arrived, and how many cycles since the row
    // word became complete". Outputs follow from those positions.
    bit             m_active = 0;
    bit             m_done   = 0;
    int             m_row    = 0;
    int             m_nchunk = 0;
    int             m_t      = 0;
    logic [BLW-1:0] m_bl     = '0;

    always @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            m_active = 0; m_done = 0; m_row = 0; m_nchunk = 0; m_t = 0; m_bl = '0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1; m_row = 0; m_nchunk = 0; m_t = 0; m_bl = '0;
            end
        end else if (abort || m_done) begin
            m_active = 0; m_done = 0;
        end else if (m_nchunk < NCH) begin
            if (din_valid) begin
                m_bl = (m_bl << DW) | BLW'(din);
                m_nchunk++;
                m_t = 0;
            end
        end else if (m_t == PULSE + 1) begin
            if (m_row == WLW - 1) m_done = 1;
            else begin
                m_row++;
                m_nchunk = 0;
            end
        end else begin
            m_t++;
        end
    end

    bit             chk_en = 0;
    bit             rec_en = 0;
    logic [BLW-1:0] pulse_bl[$];
    logic [WLW-1:0] pulse_wl[$];

    always @(negedge prog_clk) begin
        if (chk_en && !pReset) begin
            logic [WLW-1:0] e_wl;
            bit             e_ready;
            e_ready = m_active && !m_done && (m_nchunk < NCH);
            e_wl = (m_active && !m_done && m_nchunk == NCH && m_t >= 1 && m_t <= PULSE)
                   ? WLW'(1 << m_row) : '0;
            check("busy", 64'(busy), 64'(m_active));
            check("done", 64'(done), 64'(m_done));
            check("din_ready", 64'(din_ready), 64'(e_ready));
            check("wl", 64'(wl), 64'(e_wl));
            check("bl", 64'(bl), 64'(m_bl));
            check("wl_quiet_while_ready", din_ready ? 64'(wl) : 64'd0, 64'd0);
            if (rec_en && wl != '0) begin
                pulse_bl.push_back(bl);
                pulse_wl.push_back(wl);
            end
        end
    end

    // Chunk feeder: mode 0 idle, 1 continuous, 2 toggling valid, 3 random.
    int          feed_mode = 0;
    int          chunk_idx = 0;
    bit          acc_pending = 0;
    logic [31:0] cur_rand = 32'h0;

    always @(negedge prog_clk) acc_pending = din_ready && din_valid;

    always @(posedge prog_clk) begin
        #2;
        if (acc_pending) begin
            chunk_idx++;
            cur_rand = $urandom;
        end
        case (feed_mode)
            1: din_valid = 1'b1;
            2: din_valid = !din_valid;
            3: din_valid = ($urandom_range(0, 9) < 7);
            default: din_valid = 1'b0;
        endcase
        din = (feed_mode == 3) ? cur_rand[7:0] : 8'(chunk_idx + 1);
    end

    task automatic do_start();
        @(posedge prog_clk); #1;
        chunk_idx = 0;
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit, output int n);
        n = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge prog_clk);
            if (done) begin
                n = i;
                break;
            end
        end
        check(name, 64'(n != 0), 64'd1);
    endtask

    task automatic check_pulses(input string name);
        logic [BLW-1:0] rows_bl[4];
        rows_bl[0] = 40'h0102030405;
        rows_bl[1] = 40'h060708090A;
        rows_bl[2] = 40'h0B0C0D0E0F;
        rows_bl[3] = 40'h1011121314;
        check({name, "_pulse_count"}, 64'(pulse_bl.size()), 64'd8);
        for (int i = 0; i < 8 && i < pulse_bl.size(); i++) begin
            check({name, "_row_bl"}, 64'(pulse_bl[i]), 64'(rows_bl[i / 2]));
            check({name, "_row_wl"}, 64'(pulse_wl[i]), 64'(4'b0001 << (i / 2)));
        end
    endtask

    initial begin
        int n;
        int done_seen;
        logic [0:0] sw_wl[6];
        logic       sw_done[6];
        logic       sw_ready[6];
        logic       sw_busy[6];
        logic [39:0] sw_bl_setup;

        #1;
        check("reset_bl", 64'(bl), 64'd0);
        check("reset_wl", 64'(wl), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_ready", 64'(din_ready), 64'd0);
        repeat (3) @(posedge prog_clk);
        #1 pReset = 1'b0;
        chk_en = 1;

        // Full load, continuous valid
        feed_mode = 1;
        pulse_bl.delete(); pulse_wl.delete();
        rec_en = 1;
        do_start();
        wait_done("full_done_timeout", 200, n);
        check("full_done_cycle", 64'(n), 64'd37);
        rec_en = 0;
        check_pulses("full");

        // Stalled input, valid toggling every cycle
        @(posedge prog_clk); #1;
        feed_mode = 2;
        pulse_bl.delete(); pulse_wl.delete();
        rec_en = 1;
        do_start();
        wait_done("stall_done_timeout", 300, n);
        rec_en = 0;
        check_pulses("stall");

        // Abort during PULSE of row 2
        @(posedge prog_clk); #1;
        feed_mode = 1;
        do_start();
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge prog_clk);
            if (wl == 4'b0100) begin
                n = 1;
                break;
            end
        end
        check("abort_reach_row2", 64'(n), 64'd1);
        @(posedge prog_clk); #1 abort = 1'b1;
        @(posedge prog_clk); #1 abort = 1'b0;
        @(negedge prog_clk);
        check("abort_wl", 64'(wl), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_bl_held", 64'(bl), 64'h0B0C0D0E0F);
        done_seen = 0;
        repeat (20) begin
            @(negedge prog_clk);
            if (done) done_seen = 1;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);
        do_start();
        @(negedge prog_clk);
        check("restart_bl_cleared", 64'(bl), 64'd0);
        check("restart_ready", 64'(din_ready), 64'd1);
        wait_done("restart_done_timeout", 200, n);

        // start held high through a load and through DONE
        @(posedge prog_clk); #1;
        chunk_idx = 0;
        pulse_bl.delete(); pulse_wl.delete();
        rec_en = 1;
        start = 1'b1;
        wait_done("held_done_timeout", 200, n);
        rec_en = 0;
        check("held_pulse_count", 64'(pulse_bl.size()), 64'd8);
        @(negedge prog_clk);
        check("held_idle_gap", 64'(busy), 64'd0);
        @(negedge prog_clk);
        check("held_restart_busy", 64'(busy), 64'd1);
        @(posedge prog_clk); #1;
        start = 1'b0;
        abort = 1'b1;
        @(posedge prog_clk); #1 abort = 1'b0;

        // Asynchronous reset mid-row in SHIFT
        do_start();
        @(negedge prog_clk);
        @(negedge prog_clk);
        @(negedge prog_clk);
        #2 pReset = 1'b1;
        #1;
        check("areset_bl", 64'(bl), 64'd0);
        check("areset_wl", 64'(wl), 64'd0);
        check("areset_busy", 64'(busy), 64'd0);
        check("areset_ready", 64'(din_ready), 64'd0);
        @(posedge prog_clk); #1 pReset = 1'b0;
        feed_mode = 0;
        repeat (5) @(negedge prog_clk);
        check("areset_stays_idle", 64'(busy), 64'd0);

        // Randomized loads with occasional abort and stray start
        feed_mode = 3;
        for (int l = 0; l < 8; l++) begin
            do_start();
            n = 0;
            for (int c = 0; c < 400; c++) begin
                @(negedge prog_clk);
                if (done || !busy) begin
                    n = 1;
                    break;
                end
                @(posedge prog_clk); #1;
                abort = ($urandom_range(0, 79) == 0);
                start = ($urandom_range(0, 7) == 0);
            end
            check("rand_load_ends", 64'(n), 64'd1);
            @(posedge prog_clk); #1;
            abort = 1'b0;
            start = 1'b0;
            repeat (3) @(posedge prog_clk);
            #1 abort = 1'b1;
            @(posedge prog_clk); #1 abort = 1'b0;
        end
        feed_mode = 0;

        // Parameter corner: one chunk per row, one row, one-cycle pulse
        @(posedge prog_clk); #1;
        s_start = 1'b1;
        s_din   = 40'hA55A_C33C_96;
        s_valid = 1'b1;
        @(posedge prog_clk); #1;
        s_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge prog_clk);
            sw_wl[i]    = s_wl;
            sw_done[i]  = s_done;
            sw_ready[i] = s_ready;
            sw_busy[i]  = s_busy;
            if (i == 1) sw_bl_setup = s_bl;
        end
        s_valid = 1'b0;
        check("sweep_shift_ready", 64'(sw_ready[0]), 64'd1);
        check("sweep_setup_bl", 64'(sw_bl_setup), 64'hA55AC33C96);
        check("sweep_setup_wl", 64'(sw_wl[1]), 64'd0);
        check("sweep_pulse_wl", 64'(sw_wl[2]), 64'd1);
        check("sweep_hold_wl", 64'(sw_wl[3]), 64'd0);
        check("sweep_done", 64'(sw_done[4]), 64'd1);
        check("sweep_done_once", 64'(sw_done[3] | sw_done[5]), 64'd0);
        check("sweep_wl_cycles", 64'(int'(sw_wl[0]) + int'(sw_wl[1]) + int'(sw_wl[2])
                                    + int'(sw_wl[3]) + int'(sw_wl[4]) + int'(sw_wl[5])), 64'd1);
        check("sweep_busy_during", 64'(sw_busy[4]), 64'd1);
        check("sweep_idle_after", 64'(sw_busy[5]), 64'd0);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
